// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: PC, single-outstanding I-memory reads, small instruction buffer.
// Optional perf counters (perf_fetched, perf_discarded) under `define FETCH_PERF_CNT_EN.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0060,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        decode_stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_discarded
`endif
);

    localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH,
        DISCARD
    } state_t;

    state_t          state;
    logic [31:0]     pc;
    logic [31:0]     buf_pc   [BUF_DEPTH];
    logic [31:0]     buf_data [BUF_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   cnt_n;

    logic        resp_ok;
    logic        out_after;
    logic        push;
    logic        pop;
    logic        full;
    logic        drop;
    logic [31:0] redir_pc;
    logic        unused_lsb;

    assign unused_lsb = ^redirect_pc[1:0];
    assign redir_pc   = {redirect_pc[31:2], 2'b00};

    // imem_read doubles as the outstanding flag: it is held until the response.
    assign resp_ok   = imem_read && imem_resp;
    assign out_after = imem_read && !imem_resp;
    assign push      = resp_ok && (state == FETCH) && !redirect;
    assign drop      = resp_ok && (redirect || (state == DISCARD));
    assign pop       = instr_valid && !decode_stall;
    assign full      = (count == DEPTH_C);

    always_comb begin
        cnt_n = count;
        if (push && !pop) begin
            cnt_n = count + CW'(1);
        end else if (pop && !push) begin
            cnt_n = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            imem_read    <= 1'b0;
            imem_address <= 32'd0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if (out_after) begin
                // Wrong-path request still in flight: wait it out.
                state <= DISCARD;
                pc    <= redir_pc;
            end else begin
                state        <= FETCH;
                imem_read    <= 1'b1;
                imem_address <= redir_pc;
                pc           <= redir_pc + 32'd4;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= cnt_n;
            if ((state == DISCARD) && resp_ok) begin
                state <= FETCH;
            end
            if (!out_after) begin
                if (cnt_n < DEPTH_C) begin
                    imem_read    <= 1'b1;
                    imem_address <= pc;
                    pc           <= pc + 32'd4;
                end else begin
                    imem_read <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            buf_pc[wr_ptr]   <= imem_address;
            buf_data[wr_ptr] <= imem_rdata;
        end
    end

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? buf_data[rd_ptr] : NOP;
    assign instr_pc    = instr_valid ? buf_pc[rd_ptr] : 32'd0;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched   <= 32'd0;
            perf_discarded <= 32'd0;
        end else begin
            if (push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            perf_discarded <= perf_discarded + 32'(drop)
                + (redirect ? 32'(count) : 32'd0);
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full));

endmodule
